// File: rtl/dram_block_copy.sv
// Block copy engine driving both ports of a dual-port dram.
// Ports: clk/rst, start/src_addr/dst_addr/length in, busy/done/err out, dram port 1 (read) and port 2 (write).
module dram_block_copy #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr_1,
  output logic [DATA_W-1:0] mem_data_in_1,
  output logic              mem_load_1,
  input  logic [DATA_W-1:0] mem_data_out_1,
  output logic [ADDR_W-1:0] mem_addr_2,
  output logic [DATA_W-1:0] mem_data_in_2,
  output logic              mem_load_2
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              load2_q, load2_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // One extra bit so region ends cannot wrap.
  logic [ADDR_W:0] src_end, dst_end;
  logic            range_bad, ovl_bad;

  assign src_end   = {1'b0, src_addr} + {1'b0, length};
  assign dst_end   = {1'b0, dst_addr} + {1'b0, length};
  assign range_bad = (src_end > DEPTH) || (dst_end > DEPTH);
  // Destination starting inside the source would overwrite unread words.
  assign ovl_bad   = (length != '0) && (src_addr < dst_addr)
                   && ({1'b0, dst_addr} < src_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr1_q <= '0;
      addr2_q <= '0;
      rem_q   <= '0;
      load2_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      rem_q   <= rem_d;
      load2_q <= load2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    rem_d   = rem_q;
    load2_d = load2_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (range_bad || ovl_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (length == '0) begin
            err_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            addr1_d = src_addr;
            addr2_d = dst_addr;
            rem_d   = length;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // First RUN edge presents dst itself; later edges step by one.
        addr2_d = load2_q ? addr2_q : addr2_q + ONE;
        load2_d = 1'b0;
        addr1_d = addr1_q + ONE;
        rem_d   = rem_q - ONE;
        if (rem_q == ONE) state_d = DRAIN;
      end
      DRAIN: begin
        load2_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign mem_addr_1    = addr1_q;
  assign mem_data_in_1 = '0;
  assign mem_load_1    = 1'b1;
  assign mem_addr_2    = addr2_q;
  assign mem_data_in_2 = mem_data_out_1;
  assign mem_load_2    = load2_q;

endmodule

// File: tb/tb_dram_block_copy.sv
// Directed bench for dram_block_copy with a behavioural dual-port dram.
// Ports: none; drives the DUT and models the dram locally.
module tb_dram_block_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [31:0] length = '0;
  logic        busy, done, err;
  logic [31:0] mem_addr_1, mem_data_in_1, mem_data_out_1;
  logic        mem_load_1;
  logic [31:0] mem_addr_2, mem_data_in_2;
  logic        mem_load_2;

  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [1024];
  logic [31:0] dout1;

  int checks = 0;
  int failures = 0;
  int wcnt = 0, dcnt = 0, bcnt = 0, viol = 0;

  always #5 clk = ~clk;

  dram_block_copy #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .err(err),
    .mem_addr_1(mem_addr_1), .mem_data_in_1(mem_data_in_1),
    .mem_load_1(mem_load_1), .mem_data_out_1(mem_data_out_1),
    .mem_addr_2(mem_addr_2), .mem_data_in_2(mem_data_in_2),
    .mem_load_2(mem_load_2)
  );

  assign mem_data_out_1 = dout1;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (!mem_load_2 && mem_addr_2 < 32'd1024)
      mem[mem_addr_2[9:0]] <= mem_data_in_2;
    if (mem_addr_1 < 32'd1024) dout1 <= mem[mem_addr_1[9:0]];
  end

  always @(negedge clk) begin
    if (!mem_load_2) wcnt <= wcnt + 1;
    if (done) dcnt <= dcnt + 1;
    if (busy) bcnt <= bcnt + 1;
    if (!mem_load_2 && !busy) viol <= viol + 1;
  end

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int s, input int d, input int l);
    @(negedge clk);
    src_addr = 32'(s);
    dst_addr = 32'(d);
    length   = 32'(l);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  int w0, d0, b0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = 10'(i);
      pl_data = pat(i);
    end
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);

    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_addr1", mem_addr_1, 32'd0);
    chk("rst_addr2", mem_addr_2, 32'd0);
    chk("rst_load2", 32'(mem_load_2), 32'd1);
    chk("rst_load1", 32'(mem_load_1), 32'd1);
    chk("rst_din1",  mem_data_in_1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic copy of 4 words
    w0 = wcnt; d0 = dcnt; b0 = bcnt;
    go(0, 100, 4);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done");
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[100+i], pat(i));
    chk("t1_mem_after", mem[104], pat(104));
    chk("t1_writes", 32'(wcnt - w0), 32'd4);
    chk("t1_busycyc", 32'(bcnt - b0), 32'd5);
    chk("t1_dones", 32'(dcnt - d0), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // 2: zero length
    w0 = wcnt; d0 = dcnt; b0 = bcnt;
    go(5, 200, 0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t2_writes", 32'(wcnt - w0), 32'd0);
    chk("t2_busycyc", 32'(bcnt - b0), 32'd0);
    chk("t2_dones", 32'(dcnt - d0), 32'd1);
    chk("t2_err", 32'(err), 32'd0);

    // 3: range error, overlap error, legal reverse overlap
    w0 = wcnt;
    go(1020, 0, 8);
    chk("t3_rng_err", 32'(err), 32'd1);
    chk("t3_rng_done", 32'(done), 32'd1);
    chk("t3_rng_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_rng_mem0", mem[0], pat(0));
    chk("t3_rng_mem7", mem[7], pat(7));
    go(10, 12, 4);
    chk("t3_ovl_err", 32'(err), 32'd1);
    chk("t3_ovl_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t3_err_hold", 32'(err), 32'd1);
    chk("t3_writes", 32'(wcnt - w0), 32'd0);
    go(12, 10, 4);
    chk("t3_err_clr", 32'(err), 32'd0);
    wait_done("t3_done");
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("t3_mem", mem[10+i], pat(12+i));

    // 4: start while busy is ignored
    w0 = wcnt; d0 = dcnt; b0 = bcnt;
    go(300, 400, 6);
    @(negedge clk);
    src_addr = 32'd0; dst_addr = 32'd500; length = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done");
    @(negedge clk);
    @(negedge clk);
    chk("t4_writes", 32'(wcnt - w0), 32'd6);
    chk("t4_dones", 32'(dcnt - d0), 32'd1);
    chk("t4_busycyc", 32'(bcnt - b0), 32'd7);
    chk("t4_mem0", mem[400], pat(300));
    chk("t4_mem5", mem[405], pat(305));
    chk("t4_untouched", mem[500], pat(500));

    // 5: back-to-back start in the done cycle
    w0 = wcnt; d0 = dcnt;
    go(20, 600, 3);
    wait_done("t5_done_a");
    src_addr = 32'd30; dst_addr = 32'd700; length = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_b", 32'(busy), 32'd1);
    wait_done("t5_done_b");
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("t5_mem_a", mem[600+i], pat(20+i));
    for (int i = 0; i < 2; i++) chk("t5_mem_b", mem[700+i], pat(30+i));
    chk("t5_writes", 32'(wcnt - w0), 32'd5);
    chk("t5_dones", 32'(dcnt - d0), 32'd2);

    // 6: reset after two writes
    go(40, 800, 8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_load2", 32'(mem_load_2), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_load2", 32'(mem_load_2), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_mem0", mem[800], pat(40));
    chk("t6_mem1", mem[801], pat(41));
    chk("t6_mem2", mem[802], pat(802));
    chk("t6_mem7", mem[807], pat(807));
    go(50, 900, 2);
    wait_done("t6_done");
    @(negedge clk);
    chk("t6_next0", mem[900], pat(50));
    chk("t6_next1", mem[901], pat(51));
    chk("t6_err", 32'(err), 32'd0);

    chk("idle_write", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_block_copy.md
Name: dram_block_copy

Overview:
- Initiator-side engine that drives both ports of the dual-port dram to copy a contiguous block of words.
- Port 1 only reads from the source region; port 2 only writes to the destination region.
- Streams one word per cycle with a one-cycle read-to-write lag.
- Controlled by a start/busy/done handshake from the HLS datapath controller.

Parameters:
DATA_W, 32, word width (matches dram data ports)
ADDR_W, 32, address and length width (matches dram address ports)
MEM_DEPTH, 1024, number of words in the dram; used for range checking

Ports:
clk  in  1  single clock; all dram traffic is sampled on its rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a copy; sampled only when busy=0
src_addr  in  ADDR_W  first source word address; sampled with start
dst_addr  in  ADDR_W  first destination word address; sampled with start
length  in  ADDR_W  number of words to copy, 0..MEM_DEPTH; sampled with start
busy  out  1  copy in progress
done  out  1  one-cycle pulse at the end of every accepted start (success, length 0, or error)
err  out  1  status of the last accepted start: 1 = rejected; cleared when the next start is accepted
mem_addr_1  out  ADDR_W  to dram addr_1, registered
mem_data_in_1  out  DATA_W  to dram data_in_1, tied to 0
mem_load_1  out  1  to dram load_1; constant 1 (read only)
mem_data_out_1  in  DATA_W  from dram data_out_1
mem_addr_2  out  ADDR_W  to dram addr_2, registered
mem_data_in_2  out  DATA_W  to dram data_in_2; combinational copy of mem_data_out_1
mem_load_2  out  1  to dram load_2, registered; 0 = write, 1 = read/idle

Behaviour:
- dram convention: load=0 writes data_in on the edge; load=1 reads, with data_out valid after that edge.
- Reset values: busy=0, done=0, err=0, mem_addr_1=0, mem_addr_2=0, mem_load_2=1, mem_load_1=1.
- Reset is asynchronous. A reset during a copy aborts it immediately: mem_load_2 goes high at once, and any words already written stay written.
- FSM states are IDLE, RUN, DRAIN.
- Start acceptance, IDLE only: start=1 at edge E0 is accepted. start while busy=1 is ignored with no side effects.
- Argument check at E0 uses ADDR_W+1-bit arithmetic so sums cannot wrap. The start is rejected (err) if any of these holds:
  - src_addr+length > MEM_DEPTH
  - dst_addr+length > MEM_DEPTH
  - length>0 and src_addr < dst_addr < src_addr+length (forward-overlap hazard)
- dst_addr == src_addr is legal (self-copy).
- Rejected start: after E0, err=1 and done=1 for one cycle, busy stays 0, and mem_load_2 stays 1 (no writes).
- length==0: after E0, done=1 for one cycle, err=0, and no writes.
- Valid start with length=N≥1: after E0, busy=1, state=RUN, mem_addr_1=src_addr, and a read counter k=0.
- RUN, each edge:
  - The dram samples the read at mem_addr_1=src+k.
  - The engine sets mem_addr_2=dst+k and mem_load_2=0.
  - It then advances mem_addr_1 to src+k+1.
  - After the read of k=N-1 is issued, go to DRAIN. mem_addr_1 may hold any value there because port 1 is read only.
- DRAIN: the dram samples the final write (dst+N-1). After that edge, mem_load_2=1, busy=0, done=1 for one cycle, and state=IDLE.
- Timing summary:
  - Read of word k is sampled at edge E(k+1).
  - Write of word k is sampled at edge E(k+2).
  - The last write occurs at E(N+1).
  - done is high in the cycle after E(N+1).
  - Total busy time is N+1 cycles.
- mem_load_2 is 0 only in cycles where mem_addr_2 holds a valid destination address. It is never 0 while in IDLE.
- A new start may be accepted in the same cycle that done is high (back-to-back copies).
- err holds its value until the next accepted start.

Test Plan:
1. Preload mem[0..3]=A,B,C,D; start src=0 dst=100 len=4 -> mem[100..103]=A,B,C,D; mem_load_2 is 0 exactly 4 cycles; busy for 5 cycles; done pulses once; err=0.
2. start len=0 -> done pulses the cycle after start; busy never asserts; no write cycles; err=0.
3. Range error: start src=1020 dst=0 len=8 -> err=1 and done pulse; mem[0..7] unchanged. Overlap error: start src=10 dst=12 len=4 -> err=1; no writes. Then start src=12 dst=10 len=4 -> copies correctly with err cleared.
4. Assert start again while busy during a len=6 copy -> second start ignored; exactly 6 writes; a single done pulse.
5. Back-to-back: assert start in the done cycle -> second copy begins the next cycle; both blocks are correct.
6. Assert rst after 2 of 8 writes -> mem_load_2=1 and busy=0 immediately; only dst+0 and dst+1 are modified; the next start runs normally.
